// File: rtl/exec_writeback_sched.sv
// Writeback scheduler: holds execute results in a latency-indexed slot shifter,
// refuses writeback-port collisions and WAW reordering, and flags RAW hazards.
module exec_writeback_sched #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned LAT_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_rt,
  input  logic [LAT_W-1:0]  issue_latency,
  input  logic [DATA_W-1:0] issue_result,
  input  logic [ADDR_W-1:0] chk_ra,
  input  logic [ADDR_W-1:0] chk_rb,
  input  logic [ADDR_W-1:0] chk_rc,
  input  logic [2:0]        chk_en,
  output logic              hazard,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_rt,
  output logic [DATA_W-1:0] wb_data,
  output logic [LAT_W:0]    inflight
);

  localparam int unsigned SLOTS = 2 ** LAT_W;
  localparam int unsigned CNT_W = LAT_W + 1;

  logic [SLOTS-1:0]  slot_valid;
  logic [ADDR_W-1:0] slot_rt   [SLOTS];
  logic [DATA_W-1:0] slot_data [SLOTS];

  logic        collision;
  logic        waw;
  logic        accept;
  int unsigned lat_next;

  // Issue gating: the slot above the target must be free, and no older write
  // to the same register may land later than the new one.
  always_comb begin
    collision = 1'b0;
    waw       = 1'b0;
    lat_next  = 32'(issue_latency) + 32'd1;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (k == lat_next && slot_valid[k]) collision = 1'b1;
      if (k > lat_next && slot_valid[k] && slot_rt[k] == issue_rt) waw = 1'b1;
    end
  end

  assign issue_ready = !collision && !waw;
  assign accept      = issue_valid && issue_ready && !flush;

  // RAW check: slot 0 still counts as busy since there is no bypass.
  always_comb begin
    hazard = 1'b0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (slot_valid[k]) begin
        if (chk_en[0] && chk_ra == slot_rt[k]) hazard = 1'b1;
        if (chk_en[1] && chk_rb == slot_rt[k]) hazard = 1'b1;
        if (chk_en[2] && chk_rc == slot_rt[k]) hazard = 1'b1;
      end
    end
  end

  // Slot shifter; empty slots always carry zero rt/data so slot 0 drives wb_* directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid <= '0;
      for (int unsigned k = 0; k < SLOTS; k++) begin
        slot_rt[k]   <= '0;
        slot_data[k] <= '0;
      end
    end else if (flush) begin
      slot_valid <= '0;
      for (int unsigned k = 0; k < SLOTS; k++) begin
        slot_rt[k]   <= '0;
        slot_data[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < SLOTS - 1; k++) begin
        slot_valid[k] <= slot_valid[k+1];
        slot_rt[k]    <= slot_rt[k+1];
        slot_data[k]  <= slot_data[k+1];
      end
      slot_valid[SLOTS-1] <= 1'b0;
      slot_rt[SLOTS-1]    <= '0;
      slot_data[SLOTS-1]  <= '0;
      if (accept) begin
        slot_valid[issue_latency] <= 1'b1;
        slot_rt[issue_latency]    <= issue_rt;
        slot_data[issue_latency]  <= issue_result;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else begin
      inflight <= inflight - CNT_W'(slot_valid[0]) + CNT_W'(accept);
    end
  end

  assign wb_valid = slot_valid[0];
  assign wb_rt    = slot_rt[0];
  assign wb_data  = slot_data[0];

endmodule

// File: tb/tb_exec_writeback_sched.sv
// Scoreboard bench for exec_writeback_sched: pending writes are modelled as
// (rt, data, due-cycle) records and compared against the writeback port.
module tb_exec_writeback_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         issue_valid = 1'b0;
  logic         issue_ready;
  logic [6:0]   issue_rt = '0;
  logic [2:0]   issue_latency = '0;
  logic [127:0] issue_result = '0;
  logic [6:0]   chk_ra = '0, chk_rb = '0, chk_rc = '0;
  logic [2:0]   chk_en = '0;
  logic         hazard;
  logic         wb_valid;
  logic [6:0]   wb_rt;
  logic [127:0] wb_data;
  logic [3:0]   inflight;

  exec_writeback_sched dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rt(issue_rt), .issue_latency(issue_latency), .issue_result(issue_result),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .chk_rc(chk_rc), .chk_en(chk_en),
    .hazard(hazard), .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   rt;
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  // Monitor: reference model of pending writes keyed by the cycle they are due.
  always @(negedge clk) begin
    bit   found;
    exp_t cur;
    bit   m_ready;
    bit   m_haz;
    int   target;
    if (reset) begin
      sb.delete();
    end else begin
      found = 1'b0;
      cur = '{rt: '0, data: '0, due: 0};
      foreach (sb[i]) if (sb[i].due == cyc) begin found = 1'b1; cur = sb[i]; end
      check("wb_valid", 128'(wb_valid), 128'(found));
      check("wb_rt", 128'(wb_rt), 128'(cur.rt));
      check("wb_data", wb_data, cur.data);
      check("inflight", 128'(inflight), 128'(sb.size()));

      target  = cyc + int'(issue_latency) + 1;
      m_ready = 1'b1;
      foreach (sb[i]) begin
        if (sb[i].due == target) m_ready = 1'b0;
        if (sb[i].due > target && sb[i].rt == issue_rt) m_ready = 1'b0;
      end
      if (issue_valid) check("issue_ready", 128'(issue_ready), 128'(m_ready));

      m_haz = 1'b0;
      foreach (sb[i]) begin
        if (chk_en[0] && chk_ra == sb[i].rt) m_haz = 1'b1;
        if (chk_en[1] && chk_rb == sb[i].rt) m_haz = 1'b1;
        if (chk_en[2] && chk_rc == sb[i].rt) m_haz = 1'b1;
      end
      check("hazard", 128'(hazard), 128'(m_haz));

      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due == cyc) sb.delete(i);
      if (flush) sb.delete();
      else if (issue_valid && m_ready)
        sb.push_back('{rt: issue_rt, data: issue_result, due: target});
    end
    cyc++;
  end

  task automatic step(input bit v, input logic [6:0] rt, input logic [2:0] lat,
                      input logic [127:0] data, input bit fl);
    @(posedge clk);
    #1;
    issue_valid   = v;
    issue_rt      = rt;
    issue_latency = lat;
    issue_result  = data;
    flush         = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    idle(2);

    // single L=2 write
    step(1, 7'd5, 3'd2, 128'h1234, 0);
    idle(6);

    // collision, then the legal retry with L=1
    step(1, 7'd1, 3'd3, 128'h11, 0);
    step(1, 7'd2, 3'd2, 128'h22, 0);
    idle(6);
    step(1, 7'd1, 3'd3, 128'h11, 0);
    step(1, 7'd2, 3'd1, 128'h22, 0);
    idle(6);

    // WAW refusal, then a different destination
    step(1, 7'd9, 3'd6, 128'h99, 0);
    step(1, 7'd9, 3'd0, 128'h98, 0);
    idle(9);
    step(1, 7'd9, 3'd6, 128'h99, 0);
    step(1, 7'd10, 3'd0, 128'hA0, 0);
    idle(9);

    // RAW hazard through the writeback cycle
    chk_ra = 7'd20;
    chk_en = 3'b001;
    step(1, 7'd20, 3'd3, 128'h20, 0);
    idle(2);
    chk_en = 3'b000;
    idle(1);
    chk_en = 3'b001;
    idle(4);
    chk_en = 3'b000;

    // fill all eight slots, ninth accepted as the first retires
    for (int i = 0; i < 9; i++) step(1, 7'(40 + i), 3'd7, 128'(1000 + i), 0);
    idle(10);

    // flush with four in flight and a same-cycle issue
    for (int i = 0; i < 4; i++) step(1, 7'(60 + i), 3'(4 + i), 128'(2000 + i), 0);
    step(1, 7'd70, 3'd2, 128'h70, 1);
    idle(10);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      chk_ra = 7'($urandom_range(0, 15));
      chk_rb = 7'($urandom_range(0, 15));
      chk_rc = 7'($urandom_range(0, 15));
      chk_en = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 9) < 7), 7'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           {$urandom(), $urandom(), $urandom(), $urandom()}, ($urandom_range(0, 39) == 0));
    end
    chk_en = '0;
    idle(10);

    // asynchronous reset with a writeback pending in slot 0
    step(1, 7'd8, 3'd5, 128'h88, 0);
    step(1, 7'd7, 3'd0, 128'h77, 0);
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    chk_ra = 7'd7;
    chk_en = 3'b001;
    #1 reset = 1'b1;
    #1;
    check("rst_wb_valid", 128'(wb_valid), 128'd0);
    check("rst_wb_rt", 128'(wb_rt), 128'd0);
    check("rst_wb_data", wb_data, 128'd0);
    check("rst_inflight", 128'(inflight), 128'd0);
    check("rst_issue_ready", 128'(issue_ready), 128'd1);
    check("rst_hazard", 128'(hazard), 128'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    chk_en = '0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_writeback_sched.md
Name: exec_writeback_sched

Overview:
- Schedules results leaving the execute datapath into register-file writeback.
- Each issued instruction carries its destination RT, its latency code and its 128-bit result. The block holds the result in a slot shift structure and presents it on the writeback port exactly latency+1 cycles after issue.
- It also refuses issue on writeback-port collisions and WAW reordering.
- It provides a RAW scoreboard check for the decode stage.

Parameters:
- DATA_W, 128, result/writeback data width
- ADDR_W, 7, register address width (128 registers)
- LAT_W, 3, latency code width; slot count is 2**LAT_W = 8

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  synchronous: discard all in-flight entries
- issue_valid  in  1  execute stage presents an instruction
- issue_ready  out  1  combinational; issue accepted when issue_valid && issue_ready && !flush
- issue_rt  in  ADDR_W  destination register
- issue_latency  in  LAT_W  latency code L (execute encoding; 3-cycle ops use L=2)
- issue_result  in  DATA_W  computed result
- chk_ra, chk_rb, chk_rc  in  ADDR_W  decode-stage source addresses
- chk_en  in  3  per-source enable, bit0=ra, bit1=rb, bit2=rc
- hazard  out  1  combinational; an enabled source matches an in-flight RT
- wb_valid  out  1  writeback this cycle
- wb_rt  out  ADDR_W  writeback register
- wb_data  out  DATA_W  writeback data
- inflight  out  LAT_W+1  number of valid slots

Behaviour:
- State is slots 0..7, each holding valid, rt and data. Slot k retires k cycles after slot 0.
- wb_valid/wb_rt/wb_data are driven directly from slot 0.
  - When slot 0 is invalid, wb_rt and wb_data are 0.
- Every clock edge, without flush:
  - slot[k] <= slot[k+1] for k=0..6, and slot[7] <= empty.
  - If an issue is accepted, the new entry is written into slot[L], overriding the shifted value. That slot is guaranteed empty by the ready rule.
- Latency: an entry issued in cycle t appears on wb_* in cycle t+L+1 for one cycle. L=0 gives t+1; L=7 gives t+8.
- issue_ready = !collision && !waw, computed from current state and the issue_* inputs.
  - collision: L<7 and slot[L+1].valid. This slot would shift into slot[L].
  - waw: some valid slot j with j > L+1 has rt == issue_rt, i.e. an older write would land after the newer one.
  - When all slots are empty, issue_ready = 1.
- hazard = OR over valid slots 0..7 of (chk_en[i] && chk_x == slot.rt).
  - Slot 0 counts as busy: there is no bypass, and writeback occurs at the end of the cycle.
  - With chk_en=0, hazard = 0.
- inflight is a registered counter: next = current − slot0.valid + accepted.
  - Retire and accept in the same cycle leaves it unchanged.
  - It never exceeds 8.
- flush:
  - At the next edge, all slots become invalid and inflight becomes 0.
  - Any issue in the same cycle is dropped.
  - A slot 0 entry present during the flush cycle is still visible on wb_* that cycle; the register file decides whether to honour it.
- Reset, asynchronous, at any time including mid-operation:
  - all slots invalid, wb_valid=0, wb_rt=0, wb_data=0, inflight=0;
  - issue_ready=1, hazard=0.
  - After deassertion, normal operation resumes at the first edge.
- If issue_valid=0, the issue_* inputs are ignored.

Test Plan:
- Reset, then issue rt=5, L=2, data=128'h1234 at cycle 0 → wb_valid=1, rt=5, data=128'h1234 in cycle 3 only; inflight 1 in cycles 1–3, 0 in cycle 4.
- Issue rt=1 L=3 at cycle 0, then rt=2 L=2 at cycle 1 → issue_ready=0 in cycle 1 (collision). Retry with L=1 → ready=1; rt=1 retires in cycle 4, rt=2 in cycle 3.
- Issue rt=9 L=6 at cycle 0, then rt=9 L=0 at cycle 1 → ready=0 (waw). The same issue with rt=10 → accepted; wb rt=10 in cycle 2, rt=9 in cycle 7.
- rt=20 in flight, chk_ra=20 with chk_en=3'b001 → hazard=1. The same with chk_en=3'b000 → 0. hazard stays 1 through the writeback cycle and drops the cycle after.
- Fill 8 entries (L=7 each cycle, back-to-back) → inflight reaches 8, writebacks arrive on consecutive cycles in issue order. An L=7 issue accepted while slot 0 retires leaves inflight at 8.
- Assert flush with 4 entries in flight plus an issue in the same cycle → next cycle inflight=0, no later wb_valid. Then assert reset asynchronously mid-stream → outputs go to 0 immediately, without waiting for a clock edge.
